// File: rtl/load_store_unit.sv
// Load/store unit: sits between a simple request/response port and a
// single-port data memory with a registered read. Sub-word stores are done
// as read-modify-write; misaligned, illegal-size and out-of-region accesses
// fault without touching memory.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [7:0]            err_cnt,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int IDX_W = ADDR_WIDTH - 2;
  // Data region is the upper half of the word-indexed memory.
  localparam logic [IDX_W-1:0] IDX_LO = IDX_W'(MEM_DEPTH / 2);
  localparam logic [IDX_W-1:0] IDX_HI = IDX_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_WAIT, RMW_READ, RMW_WAIT, ST_WRITE, RESP
  } state_t;

  state_t state, next_state;

  logic                  accept;
  logic                  fault;
  logic [IDX_W-1:0]      idx;
  // Request fields captured at acceptance (data path, no reset needed).
  logic [1:0]            size_p1;
  logic                  uns_p1;
  logic [1:0]            off_p1;
  logic [DATA_WIDTH-1:0] wbuf_p1;

  // Shift the addressed lane down to bit 0 and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            off,
    input logic                  uns
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (size)
      SZ_B:    load_extract = uns ? {{(DATA_WIDTH-8){1'b0}}, b}
                                  : {{(DATA_WIDTH-8){b[7]}}, b};
      SZ_H:    load_extract = uns ? {{(DATA_WIDTH-16){1'b0}}, h}
                                  : {{(DATA_WIDTH-16){h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace only the addressed byte/halfword lane of the memory word.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wlo,
    input logic [1:0]            size,
    input logic [1:0]            off
  );
    lane_merge = word;
    if (size == SZ_B) lane_merge[{off, 3'b000} +: 8] = wlo[7:0];
    else              lane_merge[{off[1], 4'b0000} +: 16] = wlo;
  endfunction

  assign accept = req_valid & req_ready;

  // Fault decode on the live request; only consulted at acceptance.
  always_comb begin
    idx   = req_addr[ADDR_WIDTH-1:2];
    fault = (req_size == 2'b11)
          | ((req_size == SZ_H) & req_addr[0])
          | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
          | (idx < IDX_LO)
          | (idx >= IDX_HI);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault)              next_state = RESP;
          else if (!req_we)       next_state = LD_ISSUE;
          else if (req_size == SZ_W) next_state = ST_WRITE;
          else                    next_state = RMW_READ;
        end
      end
      LD_ISSUE: begin
        mem_rd_en  = 1'b1;
        next_state = LD_WAIT;
      end
      LD_WAIT:  next_state = RESP;
      RMW_READ: begin
        mem_rd_en  = 1'b1;
        next_state = RMW_WAIT;
      end
      RMW_WAIT: next_state = ST_WRITE;
      ST_WRITE: begin
        mem_wr_en  = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
    mem_din = mem_wr_en ? wbuf_p1 : '0;
  end

  // Response, fault counter and memory address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_cnt    <= 8'd0;
      mem_addr   <= '0;
    end else begin
      if (accept) mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      case (state)
        IDLE: if (accept && fault) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
        LD_WAIT: begin
          resp_rdata <= load_extract(mem_dout, size_p1, off_p1, uns_p1);
          resp_err   <= 1'b0;
        end
        ST_WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        RESP: if (resp_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // ---- stage p1: request capture and read-modify-write merge ----
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p1 <= req_size;
      uns_p1  <= req_unsigned;
      off_p1  <= req_addr[1:0];
      wbuf_p1 <= req_wdata;
    end else if (state == RMW_WAIT) begin
      wbuf_p1 <= lane_merge(mem_dout, wbuf_p1[15:0], size_p1, off_p1);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses; a negedge monitor pops and compares on every resp_valid.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  err_cnt;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic [31:0] mem [0:2047];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, rd_cnt = 0, wr_cnt = 0, wr_total = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .err_cnt(err_cnt), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Data memory model with registered read.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[12:2]] <= mem_din;
    if (mem_rd_en) mem_dout <= mem[mem_addr[12:2]];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare responses, count memory strobes, track acceptance.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        flag("unexpected_resp (resp_valid with nothing outstanding)");
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        check("rd_pulses", 32'(rd_cnt), 32'(e.rd));
        check("wr_pulses", 32'(wr_cnt), 32'(e.wr));
      end
    end
    if (mem_rd_en && mem_wr_en) flag("rd_wr_overlap");
    if (!mem_wr_en && mem_din != 32'd0) flag("mem_din_not_zero_when_idle");
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      wr_total++;
    end
    if (req_valid && req_ready && !reset) begin
      acc_cyc = cyc;
      rd_cnt  = 0;
      wr_cnt  = 0;
    end
  end

  // Returns at posedge+1 just after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        flag("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 50) begin
        flag("response_timeout");
        sb.delete();
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int rd, input int wr);
    exp_t e;
    e = '{exp_rd, exp_err, lat, rd, wr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    wait_accept();
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int wr0;
    logic [31:0] la [3];
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Word store then load.
    issue(1, 2'b10, 0, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1);
    issue(0, 2'b10, 0, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
    // Byte RMW into a word.
    issue(1, 2'b10, 0, 32'h1004, 32'h11223344, 32'h0, 0, 2, 0, 1);
    issue(1, 2'b00, 0, 32'h1006, 32'h0000005A, 32'h0, 0, 4, 1, 1);
    issue(0, 2'b10, 0, 32'h1004, 32'h0, 32'h115A3344, 0, 3, 1, 0);
    // Lane extraction with sign/zero extension.
    issue(1, 2'b10, 0, 32'h1008, 32'h80FF7F01, 32'h0, 0, 2, 0, 1);
    issue(0, 2'b00, 0, 32'h100B, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0);
    issue(0, 2'b00, 1, 32'h100B, 32'h0, 32'h00000080, 0, 3, 1, 0);
    issue(0, 2'b01, 0, 32'h100A, 32'h0, 32'hFFFF80FF, 0, 3, 1, 0);
    issue(0, 2'b01, 1, 32'h1008, 32'h0, 32'h00007F01, 0, 3, 1, 0);
    issue(0, 2'b00, 0, 32'h1009, 32'h0, 32'h0000007F, 0, 3, 1, 0);
    // Halfword and byte RMW with junk in upper wdata bits.
    issue(1, 2'b10, 0, 32'h100C, 32'h01020304, 32'h0, 0, 2, 0, 1);
    issue(1, 2'b01, 0, 32'h100E, 32'h1234BEEF, 32'h0, 0, 4, 1, 1);
    issue(1, 2'b00, 0, 32'h100C, 32'hFFFFFF77, 32'h0, 0, 4, 1, 1);
    issue(0, 2'b10, 1, 32'h100C, 32'h0, 32'hBEEF0377, 0, 3, 1, 0);

    // Faults.
    issue(0, 2'b10, 0, 32'h1002, 32'h0, 32'h0, 1, 1, 0, 0);
    issue(1, 2'b10, 0, 32'h0FFC, 32'h12345678, 32'h0, 1, 1, 0, 0);
    @(negedge clk);
    check("err_cnt_2", 32'(err_cnt), 32'd2);
    issue(0, 2'b11, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 0, 0);
    issue(0, 2'b01, 0, 32'h1001, 32'h0, 32'h0, 1, 1, 0, 0);
    issue(0, 2'b10, 0, 32'h2000, 32'h0, 32'h0, 1, 1, 0, 0);
    @(negedge clk);
    check("err_cnt_5", 32'(err_cnt), 32'd5);
    // The faulting word store must not have landed.
    issue(0, 2'b10, 0, 32'h1004, 32'h0, 32'h115A3344, 0, 3, 1, 0);
    for (int i = 0; i < 300; i++)
      issue(0, 2'b01, 0, 32'h1003, 32'h0, 32'h0, 1, 1, 0, 0);
    @(negedge clk);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset during RMW_WAIT abandons the halfword store.
    issue(1, 2'b10, 0, 32'h1010, 32'h55667788, 32'h0, 0, 2, 0, 1);
    wr0 = wr_total;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h1010; req_wdata = 32'h0000AAAA;
    wait_accept();
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_no_write", 32'(wr_total), 32'(wr0));
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    issue(0, 2'b10, 0, 32'h1010, 32'h0, 32'h55667788, 0, 3, 1, 0);

    // req_valid held high across three word loads.
    la[0] = 32'h1004; la[1] = 32'h1008; la[2] = 32'h100C;
    sb.push_back('{32'h115A3344, 1'b0, 3, 1, 0});
    sb.push_back('{32'h80FF7F01, 1'b0, 3, 1, 0});
    sb.push_back('{32'hBEEF0377, 1'b0, 3, 1, 0});
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = la[0];
    for (int k = 0; k < 3; k++) begin
      wait_accept();
      if (k < 2) req_addr = la[k+1];
      else       req_valid = 1'b0;
    end
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter MEM_DEPTH, default 2048, memory depth in words; data region is word indices MEM_DEPTH/2..MEM_DEPTH-1 (bytes 0x1000-0x1FFF at default).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr  input  ADDR_WIDTH  byte address.
REQ-012 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 resp_valid  output  1  one-cycle response strobe.
REQ-014 resp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
REQ-015 resp_err  output  1  access fault, qualified by resp_valid.
REQ-016 err_cnt  output  8  saturating fault counter.
REQ-017 mem_rd_en, mem_wr_en  output  1 each  data-memory read/write enables.
REQ-018 mem_addr  output  ADDR_WIDTH  word-aligned byte address {req_addr[ADDR_WIDTH-1:2],2'b00}.
REQ-019 mem_din  output  DATA_WIDTH  write data to memory.
REQ-020 mem_dout  input  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en (registered read).

Function
REQ-021 Request accepted on an edge with req_valid & req_ready; all req_* fields latched at acceptance.
REQ-022 States: IDLE, LD_ISSUE, LD_WAIT, RMW_READ, RMW_WAIT, ST_WRITE, RESP.
REQ-023 Fault at acceptance if: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; word index addr[ADDR_WIDTH-1:2] < MEM_DEPTH/2 or >= MEM_DEPTH.
REQ-024 Fault: IDLE->RESP, resp_err=1, resp_rdata=0, no mem_rd_en/mem_wr_en ever asserted; response 1 cycle after acceptance.
REQ-025 Load: IDLE->LD_ISSUE (mem_rd_en=1)->LD_WAIT (capture mem_dout)->RESP; resp_valid 3 cycles after acceptance.
REQ-026 Word store: IDLE->ST_WRITE (mem_wr_en=1, mem_din=wdata)->RESP; resp_valid 2 cycles after acceptance.
REQ-027 Byte/halfword store: IDLE->RMW_READ (mem_rd_en=1)->RMW_WAIT (merge lanes into mem_dout copy)->ST_WRITE->RESP; resp_valid 4 cycles after acceptance.
REQ-028 Little-endian lanes: byte at addr[1:0]=k occupies bits [8k+7:8k]; halfword at addr[1]=h occupies [16h+15:16h].
REQ-029 Load extraction: selected lane shifted to bit 0, extended per req_unsigned; word loads ignore req_unsigned.
REQ-030 RMW merge replaces only the addressed lane(s) with low bits of req_wdata; other bytes preserved.
REQ-031 RESP: resp_valid=1 exactly one cycle, then IDLE; req_ready=0 in every non-IDLE state, so no back-to-back overlap.
REQ-032 mem_rd_en and mem_wr_en never high simultaneously; each high exactly one cycle per access; mem_din=0 when mem_wr_en=0.
REQ-033 err_cnt increments by 1 in each RESP cycle with resp_err=1; saturates at 255.
REQ-034 resp_rdata/resp_err hold their last values outside RESP; only resp_valid qualifies them.

Reset
REQ-035 Reset forces IDLE; req_ready=1; resp_valid, resp_err, mem_rd_en, mem_wr_en=0; resp_rdata, mem_addr, mem_din=0; err_cnt=0.
REQ-036 Reset mid-operation abandons the access: no write issued, no response generated.

Verification
REQ-037 Store word 0xDEADBEEF @0x1004, then load word @0x1004 -> resp_rdata=0xDEADBEEF, resp_err=0, latencies 2 and 3 cycles.
REQ-038 Store word 0x11223344 @0x1004, store byte 0x5A @0x1006, load word @0x1004 -> 0x115A3344; byte store takes 4 cycles with one mem_rd_en then one mem_wr_en.
REQ-039 Store word 0x80FF7F01 @0x1008; lb @0x100B -> 0xFFFFFF80; lbu @0x100B -> 0x00000080; lh @0x100A -> 0xFFFF80FF; lhu @0x1008 -> 0x00007F01.
REQ-040 Load word @0x1002 and store word @0x0FFC -> each resp_err=1 one cycle after acceptance, no mem enables, err_cnt=2; 300 faults -> err_cnt=255.
REQ-041 Halfword store @0x1010 with reset pulsed during RMW_WAIT -> no mem_wr_en, no resp_valid, req_ready=1 after reset.
REQ-042 req_valid held high continuously for three word loads -> accepted only in IDLE, exactly three resp_valid pulses in order.
